inst_fetcher: RTL

//  Front-end instruction source for the decoder. Fetches 32-bit RISC-V words from the byte-wide memory arbiter port.

---
 rtl/inst_fetcher_pkg.sv | 23 ++
 rtl/inst_fetcher_queue.sv | 78 +++++++
 rtl/inst_fetcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared fetch definitions: JAL opcode, fetch FSM states, queue entry layout
// and the J-type immediate extraction shared with the decoder.
package inst_fetcher_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_WAIT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// In-order instruction queue of {pred, pc, inst}; clear overrides push/pop,
// pop on empty is ignored, head reads as zero while empty.
module inst_fetcher_queue
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  iq_entry_t                push_data,
    input  logic                     pop,
    output iq_entry_t                head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    iq_entry_t     mem_q [DEPTH];
    iq_entry_t     mem_d [DEPTH];
    logic          push_eff;
    logic          pop_eff;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A push into a full queue is accepted only when a pop frees the slot.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Byte-serial instruction fetcher feeding the decoder through an in-order queue.
// Optional JAL predecode redirect is enabled by defining FETCH_JAL_PREDICT_EN.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        inst_pred
);

    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [2:0][7:0] bytes_q, bytes_d;
    logic            rd_pend_q, rd_pend_d;
    logic [1:0]      rd_slot_q, rd_slot_d;

    logic            iq_push;
    logic            iq_full;
    logic            iq_empty;
    logic [CW-1:0]   iq_count;
    iq_entry_t       push_entry;
    iq_entry_t       head;

    logic [31:0]     word;
    logic [31:0]     next_pc;
    logic            is_jal;
    logic            pop_fire;
    logic            full_after_push;

    // Byte 3 is never stored: it arrives in the WAIT cycle and goes straight into the word.
    assign word            = {mem_rdata, bytes_q[2], bytes_q[1], bytes_q[0]};
    assign pop_fire        = inst_ready && !iq_empty;
    assign full_after_push = (iq_count == CW'(IQ_DEPTH - 1)) && !pop_fire;

`ifdef FETCH_JAL_PREDICT_EN
    always_comb begin
        is_jal  = (word[6:0] == OPC_JAL);
        next_pc = is_jal ? (pc_q + imm_j(word)) : (pc_q + 32'd4);
    end
`else
    always_comb begin
        is_jal  = 1'b0;
        next_pc = pc_q + 32'd4;
    end
`endif

    assign push_entry = '{pred: is_jal, pc: pc_q, inst: word};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_idx_d = byte_idx_q;
        bytes_d    = bytes_q;
        rd_pend_d  = 1'b0;
        rd_slot_d  = rd_slot_q;
        iq_push    = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;

        if (rd_pend_q) begin
            case (rd_slot_q)
                2'd0:    bytes_d[0] = mem_rdata;
                2'd1:    bytes_d[1] = mem_rdata;
                2'd2:    bytes_d[2] = mem_rdata;
                default: ;
            endcase
        end

        case (state_q)
            FETCH_IDLE: begin
                // A pop this cycle frees a slot, so fetching resumes immediately.
                if (!iq_full || pop_fire) begin
                    state_d = FETCH_ISSUE;
                end
            end
            FETCH_ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + {30'd0, byte_idx_q};
                if (mem_gnt) begin
                    rd_pend_d  = 1'b1;
                    rd_slot_d  = byte_idx_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                iq_push    = 1'b1;
                pc_d       = next_pc;
                byte_idx_d = 2'd0;
                state_d    = full_after_push ? FETCH_IDLE : FETCH_ISSUE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (flush) begin
            state_d    = FETCH_ISSUE;
            pc_d       = flush_pc;
            byte_idx_d = 2'd0;
            rd_pend_d  = 1'b0;
            iq_push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            byte_idx_q <= 2'd0;
            bytes_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_slot_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_idx_q <= byte_idx_d;
            bytes_q    <= bytes_d;
            rd_pend_q  <= rd_pend_d;
            rd_slot_q  <= rd_slot_d;
        end
    end

    inst_fetcher_queue #(
        .DEPTH(IQ_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (iq_push),
        .push_data(push_entry),
        .pop      (inst_ready),
        .head_data(head),
        .full     (iq_full),
        .empty    (iq_empty),
        .count    (iq_count)
    );

    assign inst_valid = !iq_empty;
    assign inst_out   = head.inst;
    assign inst_pc    = head.pc;
    assign inst_pred  = head.pred;

endmodule
